conv_state_seq: RTL and testbench
=================================

// Module: conv_state_seq
// PURPOSE
//  Top-level conv sequencer: owns the current_state FSM consumed by the conv control decoder.
//  Per output pixel it walks INIT -> A (bias/scale preload) -> B (accumulate over input-channel
//  groups) -> C (MAC/adder pipeline drain + result handoff).
//  It honours the decoder's state_rst request and handshakes with the feature-data source
//  and the result sink.
// PARAMETERS
//  MAC_IN_NUM           9    MAC inputs per group (informational; sizes nothing here)
//  MAC_OUT_NUM          18   MAC outputs per pixel (informational)
//  MULT_PIPELINE_STAGE  2    multiplier pipeline depth
//  DRAIN_CYCLES         MULT_PIPELINE_STAGE+1   cycles spent in C before out_valid
//  CNT_WIDTH            16   width of cfg and progress counters
// PORTS
//  clk            in   1          clock; all logic on rising edge
//  rst            in   1          reset, synchronous, active-high
//  start          in   1          pulse: begin a layer with current cfg_*; ignored when busy=1
//  cfg_ic_groups  in   CNT_WIDTH  input-channel groups per pixel (beats in B), sampled at start
//  cfg_pixels     in   CNT_WIDTH  output pixels per layer, sampled at start
//  in_valid       in   1          source has a feature/weight group beat
//  in_ready       out  1          sequencer accepts beat (=1 only in B)
//  out_valid      out  1          pixel result ready for sink
//  out_ready      in   1          sink accepts result
//  state_rst      in   1          abort request from conv control decoder
//  current_state  out  3          FSM state: INIT=000 A=001 B=010 C=011
//  busy           out  1          current_state != INIT
//  done           out  1          one-cycle pulse: layer completed normally
//  pixel_cnt      out  CNT_WIDTH  index of pixel in progress
//  group_cnt      out  CNT_WIDTH  index of next group beat in B
// BEHAVIOUR
//  - Reset (rst=1 at edge): current_state=INIT; done, counters, drain_cnt, latched cfg all 0.
//    Outputs derived from state follow: in_ready=0, out_valid=0, busy=0.
//  - INIT: start & both cfg!=0 -> latch cfg, pixel_cnt=0, next A.
//    start with either cfg==0 -> stay INIT, done=1 next cycle.
//  - A: exactly 1 cycle; group_cnt<=0; next B.
//  - B: in_ready=1. Each in_valid&in_ready: group_cnt++.
//    Accept with group_cnt==cfg_ic_groups-1 -> next C, drain_cnt<=0.
//    in_valid=0 -> hold state and counts (stall).
//  - C: drain_cnt increments to DRAIN_CYCLES and saturates there.
//    out_valid=(state==C)&&(drain_cnt==DRAIN_CYCLES); holds until out_ready.
//    On out_valid&out_ready:
//      pixel_cnt==cfg_pixels-1 -> INIT, done=1 that next cycle.
//      else pixel_cnt++, next A.
//  - state_rst=1 in any cycle: next state INIT, all counters cleared, done stays 0.
//    Priority: rst > state_rst > start/handshakes.
//  - start while busy: no effect. cfg_* changes while busy: no effect (latched copy used).
//  - Latency, no stalls, start sampled cycle 0:
//      A@1; B@2..G+1; C@G+2; out_valid@G+2+DRAIN_CYCLES.
//    Each further pixel adds G+2+DRAIN_CYCLES cycles, provided out_ready is already high.
//  - Counters are modulo 2^CNT_WIDTH. cfg==2^CNT_WIDTH-1 is legal and must terminate correctly.
// STRUCTURE
//  - Shared package conv_pkg: state encodings INIT/A/B/C (3-bit) and SCALE_* codes.
//    ConvCtrl and this block both import them; no local redefinition.
//  - One sub-module is natural: conv_cnt (clear/enable/terminal-compare up-counter).
//    Instantiated for group_cnt, pixel_cnt, drain_cnt.
// TESTING
//  1. G=4,P=1, in_valid=1, out_ready=1, start@0:
//     A@1, B@2-5, C@6, out_valid@9, INIT+done@10.
//  2. G=3,P=2, in_valid low cycles 3-4:
//     B extended 2 cycles; group_cnt holds; pixel_cnt 0->1; single done at end.
//  3. out_ready low 5 cycles after out_valid:
//     out_valid stays 1, state C held, pixel_cnt unchanged until accept.
//  4. state_rst pulse mid-B (group_cnt=2):
//     next cycle INIT, counters 0, done=0; new start runs cleanly.
//  5. start with cfg_ic_groups=0 -> done@1, never leaves INIT.
//     start while busy -> ignored; cfg change while busy -> no effect.
//  6. rst asserted during C -> next cycle all outputs at reset values; out_valid drops.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared conv definitions: sequencer state encoding, scale codes and pipeline timing constants.
// Imported by the conv control decoder and the state sequencer.
package conv_pkg;

    localparam int CNT_WIDTH           = 16;
    localparam int MAC_IN_NUM          = 9;
    localparam int MAC_OUT_NUM         = 18;
    localparam int MULT_PIPELINE_STAGE = 2;
    localparam int DRAIN_CYCLES        = MULT_PIPELINE_STAGE + 1;
    localparam int DRAIN_WIDTH         = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_INIT = 3'b000,
        ST_A    = 3'b001,
        ST_B    = 3'b010,
        ST_C    = 3'b011
    } conv_state_e;

    typedef enum logic [1:0] {
        SCALE_NONE   = 2'b00,
        SCALE_SHIFT  = 2'b01,
        SCALE_MUL    = 2'b10,
        SCALE_BYPASS = 2'b11
    } scale_code_e;

    // Terminal index for a non-zero count; wraps modulo 2^CNT_WIDTH like the counters.
    function automatic logic [CNT_WIDTH-1:0] last_idx(input logic [CNT_WIDTH-1:0] cfg);
        return cfg - CNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/conv_cnt.sv
// Up-counter with synchronous clear (priority over enable) and an equality flag
// against a caller-supplied terminal value.
module conv_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] term_i,
    output logic [W-1:0] cnt_o,
    output logic         term_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign term_o = (cnt_q == term_i);

endmodule

// File: rtl/conv_state_seq.sv
// Conv pixel sequencer: INIT -> A (preload) -> B (group beats) -> C (drain + handoff) per pixel,
// with decoder abort (state_rst) and valid/ready handshakes on both sides.
module conv_state_seq
    import conv_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] cfg_ic_groups,
    input  logic [CNT_WIDTH-1:0] cfg_pixels,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic                 state_rst,
    output logic [2:0]           current_state,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] pixel_cnt,
    output logic [CNT_WIDTH-1:0] group_cnt
);

    conv_state_e          state_q, state_d;
    logic                 done_q, done_d;
    logic [CNT_WIDTH-1:0] cfg_g_q, cfg_g_d;
    logic [CNT_WIDTH-1:0] cfg_p_q, cfg_p_d;

    logic                   grp_clr_s, grp_en_s, grp_last_s;
    logic                   pix_clr_s, pix_en_s, pix_last_s;
    logic                   drn_clr_s, drn_en_s, drn_full_s;
    logic [DRAIN_WIDTH-1:0] drn_cnt_s;
    logic                   cfg_ok_s, deliver_s;

    assign cfg_ok_s  = (cfg_ic_groups != CNT_WIDTH'(0)) && (cfg_pixels != CNT_WIDTH'(0));
    assign deliver_s = out_valid && out_ready;

    conv_cnt #(.W(CNT_WIDTH)) u_group_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (grp_clr_s),
        .en_i   (grp_en_s),
        .term_i (last_idx(cfg_g_q)),
        .cnt_o  (group_cnt),
        .term_o (grp_last_s)
    );

    conv_cnt #(.W(CNT_WIDTH)) u_pixel_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (pix_clr_s),
        .en_i   (pix_en_s),
        .term_i (last_idx(cfg_p_q)),
        .cnt_o  (pixel_cnt),
        .term_o (pix_last_s)
    );

    // Drain counter saturates at DRAIN_CYCLES, which is exactly when the result is presented.
    conv_cnt #(.W(DRAIN_WIDTH)) u_drain_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (drn_clr_s),
        .en_i   (drn_en_s),
        .term_i (DRAIN_WIDTH'(DRAIN_CYCLES)),
        .cnt_o  (drn_cnt_s),
        .term_o (drn_full_s)
    );

    always_comb begin
        state_d   = state_q;
        done_d    = 1'b0;
        cfg_g_d   = cfg_g_q;
        cfg_p_d   = cfg_p_q;
        grp_clr_s = 1'b0;
        grp_en_s  = 1'b0;
        pix_clr_s = 1'b0;
        pix_en_s  = 1'b0;
        drn_clr_s = 1'b0;
        drn_en_s  = 1'b0;
        if (state_rst) begin
            state_d   = ST_INIT;
            grp_clr_s = 1'b1;
            pix_clr_s = 1'b1;
            drn_clr_s = 1'b1;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (start && cfg_ok_s) begin
                        cfg_g_d   = cfg_ic_groups;
                        cfg_p_d   = cfg_pixels;
                        pix_clr_s = 1'b1;
                        state_d   = ST_A;
                    end else if (start) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_INIT;
                    end
                end
                ST_A: begin
                    grp_clr_s = 1'b1;
                    state_d   = ST_B;
                end
                ST_B: begin
                    if (in_valid) begin
                        grp_en_s = 1'b1;
                        if (grp_last_s) begin
                            drn_clr_s = 1'b1;
                            state_d   = ST_C;
                        end else begin
                            state_d = ST_B;
                        end
                    end else begin
                        state_d = ST_B;
                    end
                end
                ST_C: begin
                    drn_en_s = (drn_cnt_s != DRAIN_WIDTH'(DRAIN_CYCLES));
                    if (deliver_s && pix_last_s) begin
                        done_d  = 1'b1;
                        state_d = ST_INIT;
                    end else if (deliver_s) begin
                        pix_en_s = 1'b1;
                        state_d  = ST_A;
                    end else begin
                        state_d = ST_C;
                    end
                end
                default: begin
                    state_d = ST_INIT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            done_q  <= 1'b0;
            cfg_g_q <= '0;
            cfg_p_q <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            cfg_g_q <= cfg_g_d;
            cfg_p_q <= cfg_p_d;
        end
    end

    assign current_state = state_q;
    assign busy          = (state_q != ST_INIT);
    assign in_ready      = (state_q == ST_B);
    assign out_valid     = (state_q == ST_C) && drn_full_s;
    assign done          = done_q;

endmodule

// File: tb/tb_conv_state_seq.sv
// Bench for conv_state_seq: directed scenarios plus randomized layers, every cycle compared
// against a countdown-style behavioural model of the sequencing rules.
module tb_conv_state_seq;

    localparam int DRAIN = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] cfg_ic_groups = 16'd0;
    logic [15:0] cfg_pixels = 16'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        state_rst = 1'b0;
    logic [2:0]  current_state;
    logic        busy;
    logic        done;
    logic [15:0] pixel_cnt;
    logic [15:0] group_cnt;

    always #5 clk = ~clk;

    conv_state_seq dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .cfg_ic_groups (cfg_ic_groups),
        .cfg_pixels    (cfg_pixels),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .state_rst     (state_rst),
        .current_state (current_state),
        .busy          (busy),
        .done          (done),
        .pixel_cnt     (pixel_cnt),
        .group_cnt     (group_cnt)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int s_start = 0;

    // Model: phase 0=INIT 1=A 2=B 3=C; beats and drain tracked as countdowns.
    int m_phase = 0, m_left = 0, m_wait = 0, m_pix = 0, m_grp = 0, m_G = 0, m_P = 0;
    bit m_done = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_phase = 0; m_pix = 0; m_grp = 0; m_wait = 0; m_left = 0;
            m_G = 0; m_P = 0; m_done = 1'b0;
        end else if (state_rst) begin
            m_phase = 0; m_pix = 0; m_grp = 0; m_wait = 0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            case (m_phase)
                0: if (start) begin
                    if (cfg_ic_groups == 16'd0 || cfg_pixels == 16'd0) m_done = 1'b1;
                    else begin
                        m_G = int'(cfg_ic_groups); m_P = int'(cfg_pixels);
                        m_pix = 0; m_phase = 1;
                    end
                end
                1: begin m_grp = 0; m_left = m_G; m_phase = 2; end
                2: if (in_valid) begin
                    m_grp = (m_grp + 1) % 65536;
                    m_left--;
                    if (m_left == 0) begin m_phase = 3; m_wait = DRAIN; end
                end
                3: if (m_wait > 0) m_wait--;
                   else if (out_ready) begin
                       if (m_pix == m_P - 1) begin m_phase = 0; m_done = 1'b1; end
                       else begin m_pix++; m_phase = 1; end
                   end
                default: ;
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        cyc++;
        @(negedge clk);
        chk("state",     32'(current_state), 32'(m_phase));
        chk("busy",      32'(busy),          32'(m_phase != 0));
        chk("in_ready",  32'(in_ready),      32'(m_phase == 2));
        chk("out_valid", 32'(out_valid),     32'(m_phase == 3 && m_wait == 0));
        chk("done",      32'(done),          32'(m_done));
        chk("pixel_cnt", 32'(pixel_cnt),     32'(m_pix));
        chk("group_cnt", 32'(group_cnt),     32'(m_grp));
    endtask

    function automatic int rel();
        return cyc - s_start + 1;
    endfunction

    task automatic start_layer(input int g, input int p);
        cfg_ic_groups = 16'(g);
        cfg_pixels = 16'(p);
        start = 1'b1;
        tick();
        s_start = cyc;
        start = 1'b0;
    endtask

    task automatic wait_for(input bit want_ov, input int budget, output int at);
        at = -1;
        for (int c = 0; c < budget; c++) begin
            tick();
            if ((want_ov ? out_valid : done) === 1'b1) begin
                at = rel();
                break;
            end
        end
    endtask

    initial begin
        int at;
        int n;
        // Reset
        tick();
        tick();
        rst = 1'b0;
        tick();

        // 1: G=4, P=1, no stalls
        in_valid = 1'b1; out_ready = 1'b1;
        start_layer(4, 1);
        wait_for(1'b1, 20, at);
        chk("t1_out_valid_cycle", 32'(at), 32'd9);
        wait_for(1'b0, 5, at);
        chk("t1_done_cycle", 32'(at), 32'd10);
        tick();

        // 2: G=3, P=2, in_valid low in cycles 3-4
        start_layer(3, 2);
        n = 0; at = -1;
        for (int c = 0; c < 40; c++) begin
            in_valid = !(rel() == 3 || rel() == 4);
            tick();
            if (done === 1'b1) begin
                n++;
                if (at < 0) at = rel();
            end
        end
        chk("t2_done_count", 32'(n), 32'd1);
        chk("t2_done_cycle", 32'(at), 32'd19);
        in_valid = 1'b1;

        // 3: sink back-pressure for 5 cycles
        out_ready = 1'b0;
        start_layer(1, 1);
        wait_for(1'b1, 20, at);
        chk("t3_out_valid_cycle", 32'(at), 32'd6);
        for (int c = 0; c < 5; c++) tick();
        chk("t3_state_held", 32'(current_state), 32'd3);
        out_ready = 1'b1;
        wait_for(1'b0, 5, at);
        chk("t3_done_cycle", 32'(at), 32'd12);

        // 4: abort mid-B, then a clean restart
        start_layer(5, 2);
        tick(); tick(); tick();
        chk("t4_group_before_abort", 32'(group_cnt), 32'd2);
        state_rst = 1'b1;
        tick();
        state_rst = 1'b0;
        chk("t4_abort_state", 32'(current_state), 32'd0);
        chk("t4_abort_done", 32'(done), 32'd0);
        start_layer(2, 1);
        wait_for(1'b0, 20, at);
        chk("t4_restart_done_cycle", 32'(at), 32'd8);

        // 5: zero cfg, start/cfg changes while busy
        start_layer(0, 5);
        chk("t5_zero_groups_done", 32'(done), 32'd1);
        chk("t5_zero_groups_state", 32'(current_state), 32'd0);
        tick();
        start_layer(3, 0);
        chk("t5_zero_pixels_done", 32'(done), 32'd1);
        tick();
        start_layer(2, 1);
        tick();
        cfg_ic_groups = 16'd7; cfg_pixels = 16'd7; start = 1'b1;
        tick();
        start = 1'b0; cfg_ic_groups = 16'd9;
        wait_for(1'b0, 20, at);
        chk("t5_busy_start_ignored", 32'(at), 32'd8);
        tick();

        // 6: rst while a result is pending
        out_ready = 1'b0;
        start_layer(1, 1);
        wait_for(1'b1, 20, at);
        chk("t6_out_valid_cycle", 32'(at), 32'd6);
        rst = 1'b1;
        tick();
        chk("t6_rst_out_valid", 32'(out_valid), 32'd0);
        rst = 1'b0; out_ready = 1'b1;
        tick();

        // Randomized layers with stalls, back-pressure, stray starts and one abort
        for (int L = 0; L < 10; L++) begin
            in_valid = 1'b1; out_ready = 1'b1;
            start_layer((L == 3) ? 0 : int'($urandom_range(1, 6)), int'($urandom_range(1, 3)));
            for (int c = 0; c < 400; c++) begin
                if (m_phase == 0) break;
                in_valid = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 2) != 0);
                start = ($urandom_range(0, 7) == 0);
                cfg_ic_groups = 16'($urandom_range(0, 9));
                cfg_pixels = 16'($urandom_range(0, 9));
                state_rst = (L == 5 && c == 7);
                tick();
            end
            start = 1'b0; state_rst = 1'b0; in_valid = 1'b0;
            tick();
            chk("rand_idle", 32'(busy), 32'd0);
        end

        // Largest legal group count must still terminate
        in_valid = 1'b1; out_ready = 1'b1;
        start_layer(65535, 1);
        wait_for(1'b0, 65600, at);
        chk("max_groups_done_cycle", 32'(at), 32'd65541);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
